// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads words from the flash read controller and writes them into SRAM
// through a ready-handshake port, once after reset (AUTO_START) or on each accepted start.
module flash_boot_loader #(
  parameter int unsigned FLASH_ADDR_W = 23,
  parameter int unsigned RAM_ADDR_W   = 20,
  parameter int unsigned FLASH_BASE   = 0,
  parameter int unsigned RAM_BASE     = 0,
  parameter int unsigned WORD_COUNT   = 1024,
  parameter int unsigned READ_WAIT    = 8,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic [FLASH_ADDR_W-1:0] bus_addr_o,
  output logic                    read_op_o,
  input  logic [31:0]             bus_data_i,
  output logic [RAM_ADDR_W-1:0]   ram_addr_o,
  output logic [31:0]             ram_wdata_o,
  output logic                    ram_we_o,
  input  logic                    ram_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             words_done_o
);

  localparam int unsigned CNT_W = (READ_WAIT > 32'd1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT - 32'd1);
  localparam logic [FLASH_ADDR_W-1:0] FLASH_BASE_A = FLASH_ADDR_W'(FLASH_BASE);
  localparam logic [RAM_ADDR_W-1:0]   RAM_BASE_A   = RAM_ADDR_W'(RAM_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_GAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    arm_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FLASH_ADDR_W-1:0] bus_addr_q;
  logic [RAM_ADDR_W-1:0]   ram_addr_q;
  logic [31:0]             ram_wdata_q;
  logic                    read_op_q;
  logic                    ram_we_q;
  logic                    busy_q;
  logic                    done_q;
  logic [31:0]             words_done_q;
  logic [31:0]             words_done_d;

  assign words_done_d = words_done_q + 32'd1;

  // Copy sequencer; every output is a register so read_op/ram_we are glitch-free
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      arm_q        <= (AUTO_START != 32'd0);
      cnt_q        <= '0;
      bus_addr_q   <= FLASH_BASE_A;
      ram_addr_q   <= RAM_BASE_A;
      ram_wdata_q  <= 32'd0;
      read_op_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_done_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i || arm_q) begin
            arm_q        <= 1'b0;
            cnt_q        <= '0;
            words_done_q <= 32'd0;
            bus_addr_q   <= FLASH_BASE_A;
            ram_addr_q   <= RAM_BASE_A;
            if (WORD_COUNT == 32'd0) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              read_op_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (cnt_q == CNT_LAST) begin
            ram_wdata_q <= bus_data_i;
            read_op_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          ram_we_q <= 1'b1;
          state_q  <= S_WR;
        end
        S_WR: begin
          if (ram_ready_i) begin
            ram_we_q     <= 1'b0;
            words_done_q <= words_done_d;
            bus_addr_q   <= bus_addr_q + FLASH_ADDR_W'(4);
            ram_addr_q   <= ram_addr_q + RAM_ADDR_W'(1);
            if (words_done_d == WORD_COUNT) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              read_op_q <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          read_op_q <= 1'b0;
          ram_we_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_addr_o   = bus_addr_q;
  assign read_op_o    = read_op_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign ram_we_o     = ram_we_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_done_o = words_done_q;

endmodule
